// File: rtl/intan_peripheral_emulator_if.sv
// SPI-style link between an Intan headstage controller and the emulated peripheral.
// The controller owns chip select, serial clock and command data; the peripheral returns two response pins.
interface intan_peripheral_emulator_if;
    logic csn;
    logic sclk;
    logic copi;
    logic cipo0;
    logic cipo1;

    modport master (output csn, output sclk, output copi, input cipo0, input cipo1);
    modport slave  (input csn, input sclk, input copi, output cipo0, output cipo1);
endinterface

// File: rtl/intan_peripheral_emulator.sv
// Emulates an Intan-style amplifier chip: decodes 16-bit SPI commands and returns
// four lane words per frame, pipelined two valid frames behind the command.
module intan_peripheral_emulator #(
    parameter int unsigned DDR_EN   = 1,
    parameter logic [7:0]  CHIP_ID  = 8'd4,
    parameter logic [7:0]  NUM_AMPS = 8'd64
) (
    input  logic                              clk,
    input  logic                              rstn,
    intan_peripheral_emulator_if.slave        spi,
    output logic [31:0]                       frame_count,
    output logic [15:0]                       error_count
);
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned NUM_REGS  = 22;
    localparam logic [4:0]  EDGE_SAT  = 5'd17;
    localparam logic [4:0]  EDGE_OK   = 5'd16;
    localparam logic [15:0] CMD_CAL   = 16'h5500;
    localparam logic [15:0] CMD_CLR   = 16'h6A00;
    localparam bit          DDR       = (DDR_EN != 0);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t      r_state;
    logic        r_csn_q, r_csn_q2, r_sclk_q, r_sclk_q2, r_copi_q;
    logic [15:0] r_cmd;
    logic [4:0]  r_edge_cnt;
    logic        r_frame_ok;
    logic        r_pend;
    logic [3:0]  r_bit;
    logic        r_phase_b;
    logic [15:0] r_lane  [NUM_LANES];
    logic [15:0] r_pipe0 [NUM_LANES];
    logic [15:0] r_pipe1 [NUM_LANES];
    logic [7:0]  r_regs  [NUM_REGS];
    logic [7:0]  r_sample;
    logic        r_cipo0, r_cipo1;

    logic        w_csn_fall, w_csn_rise, w_sclk_rise, w_sclk_fall;
    logic [5:0]  w_addr;
    logic [7:0]  w_data;
    logic [7:0]  w_rd_data;
    logic        w_wr_en, w_sample_inc, w_sample_clr;
    logic [15:0] w_resp [NUM_LANES];

    assign w_csn_fall  =  r_csn_q2 & ~r_csn_q;
    assign w_csn_rise  = ~r_csn_q2 &  r_csn_q;
    assign w_sclk_rise = ~r_sclk_q2 &  r_sclk_q;
    assign w_sclk_fall =  r_sclk_q2 & ~r_sclk_q;
    assign w_addr      = r_cmd[13:8];
    assign w_data      = r_cmd[7:0];
    assign spi.cipo0   = r_cipo0;
    assign spi.cipo1   = r_cipo1;

    // Register map read port
    always_comb begin
        w_rd_data = 8'h00;
        case (w_addr)
            6'd40:   w_rd_data = 8'h49;
            6'd41:   w_rd_data = 8'h4E;
            6'd42:   w_rd_data = 8'h54;
            6'd43:   w_rd_data = 8'h41;
            6'd44:   w_rd_data = 8'h4E;
            6'd60:   w_rd_data = 8'h01;
            6'd61:   w_rd_data = 8'h00;
            6'd62:   w_rd_data = NUM_AMPS;
            6'd63:   w_rd_data = CHIP_ID;
            default: if (w_addr < 6'(NUM_REGS)) w_rd_data = r_regs[w_addr[4:0]];
        endcase
    end

    // Command decode and per-lane response words
    always_comb begin
        w_wr_en      = 1'b0;
        w_sample_inc = 1'b0;
        w_sample_clr = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) w_resp[l] = 16'h0000;
        if (r_cmd[15:14] == 2'b00) begin
            for (int l = 0; l < NUM_LANES; l++) w_resp[l] = {2'(l), w_addr, r_sample};
            w_sample_inc = (w_addr == 6'd0);
        end else if (r_cmd == CMD_CAL || r_cmd == CMD_CLR) begin
            for (int l = 0; l < NUM_LANES; l++) w_resp[l] = 16'h8000;
            w_sample_clr = (r_cmd == CMD_CLR);
        end else if (r_cmd[15:14] == 2'b10) begin
            for (int l = 0; l < NUM_LANES; l++) w_resp[l] = {8'hFF, w_data};
            w_wr_en = (w_addr < 6'(NUM_REGS));
        end else if (r_cmd[15:14] == 2'b11) begin
            for (int l = 0; l < NUM_LANES; l++) w_resp[l] = {8'h00, w_rd_data};
        end
    end

    // Input sync, frame FSM, command execution and output lanes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // Load synchronisers with live pins so a held-low csn is not seen as a new frame
            r_csn_q     <= spi.csn;
            r_csn_q2    <= spi.csn;
            r_sclk_q    <= spi.sclk;
            r_sclk_q2   <= spi.sclk;
            r_copi_q    <= 1'b0;
            r_state     <= S_IDLE;
            r_cmd       <= 16'h0000;
            r_edge_cnt  <= 5'd0;
            r_frame_ok  <= 1'b0;
            r_pend      <= 1'b0;
            r_bit       <= 4'd15;
            r_phase_b   <= 1'b0;
            r_sample    <= 8'h00;
            r_cipo0     <= 1'b0;
            r_cipo1     <= 1'b0;
            frame_count <= 32'd0;
            error_count <= 16'd0;
            for (int l = 0; l < NUM_LANES; l++) begin
                r_lane[l]  <= 16'h0000;
                r_pipe0[l] <= 16'h0000;
                r_pipe1[l] <= 16'h0000;
            end
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
        end else begin
            r_csn_q   <= spi.csn;
            r_csn_q2  <= r_csn_q;
            r_sclk_q  <= spi.sclk;
            r_sclk_q2 <= r_sclk_q;
            r_copi_q  <= spi.copi;
            r_cipo0   <= 1'b0;
            r_cipo1   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_csn_fall || r_pend) begin
                        r_state    <= S_ACTIVE;
                        r_pend     <= 1'b0;
                        r_cmd      <= 16'h0000;
                        r_edge_cnt <= 5'd0;
                        r_bit      <= 4'd15;
                        r_phase_b  <= 1'b0;
                        r_lane     <= r_pipe1;
                    end
                end
                S_ACTIVE: begin
                    r_cipo0 <= (DDR && r_phase_b) ? r_lane[1][r_bit] : r_lane[0][r_bit];
                    r_cipo1 <= (DDR && r_phase_b) ? r_lane[3][r_bit] : r_lane[2][r_bit];
                    // csn rising edge wins over any sclk edge in the same cycle
                    if (w_csn_rise) begin
                        r_state    <= S_DONE;
                        r_frame_ok <= (r_edge_cnt == EDGE_OK);
                    end else if (w_sclk_rise) begin
                        r_cmd     <= {r_cmd[14:0], r_copi_q};
                        r_phase_b <= 1'b1;
                        if (r_edge_cnt != EDGE_SAT) r_edge_cnt <= r_edge_cnt + 5'd1;
                    end else if (w_sclk_fall) begin
                        r_phase_b <= 1'b0;
                        if (r_bit != 4'd0) r_bit <= r_bit - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_csn_fall) r_pend <= 1'b1;
                    if (r_frame_ok) begin
                        frame_count <= frame_count + 32'd1;
                        r_pipe0     <= w_resp;
                        r_pipe1     <= r_pipe0;
                        if (w_wr_en) r_regs[w_addr[4:0]] <= w_data;
                        if (w_sample_clr)      r_sample <= 8'h00;
                        else if (w_sample_inc) r_sample <= r_sample + 8'h01;
                    end else if (error_count != 16'hFFFF) begin
                        error_count <= error_count + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intan_peripheral_emulator.sv
// Bench for intan_peripheral_emulator: drives SPI frames and scoreboards the
// two-frame-delayed lane words against a behavioural model of the chip.
module tb_intan_peripheral_emulator;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] frame_count;
    logic [15:0] error_count;

    always #5 clk = ~clk;

    intan_peripheral_emulator_if spi ();

    intan_peripheral_emulator #(.DDR_EN(1), .CHIP_ID(8'd4), .NUM_AMPS(8'd64)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .spi         (spi),
        .frame_count (frame_count),
        .error_count (error_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0]  sb_q [$];
    logic [7:0]   m_regs [22];
    logic [7:0]   m_sample;
    int unsigned  m_frames;
    int unsigned  m_errors;

    task automatic model_reset();
        sb_q.delete();
        sb_q.push_back(64'h0);
        sb_q.push_back(64'h0);
        for (int i = 0; i < 22; i++) m_regs[i] = 8'h00;
        m_sample = 8'h00;
        m_frames = 0;
        m_errors = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] a);
        case (a)
            6'd40: return 8'h49;
            6'd41: return 8'h4E;
            6'd42: return 8'h54;
            6'd43: return 8'h41;
            6'd44: return 8'h4E;
            6'd60: return 8'h01;
            6'd62: return 8'd64;
            6'd63: return 8'd4;
            default: return (a < 6'd22) ? m_regs[a] : 8'h00;
        endcase
    endfunction

    // Returns {lane0, lane1, lane2, lane3} for one executed command
    task automatic model_exec(input logic [15:0] cmd, output logic [63:0] r);
        logic [5:0]  a;
        logic [15:0] w;
        a = cmd[13:8];
        w = 16'h0000;
        if (cmd[15:14] == 2'b00) begin
            r = {2'd0, a, m_sample, 2'd1, a, m_sample, 2'd2, a, m_sample, 2'd3, a, m_sample};
            if (a == 6'd0) m_sample = m_sample + 8'd1;
        end else begin
            if (cmd == 16'h5500) w = 16'h8000;
            else if (cmd == 16'h6A00) begin w = 16'h8000; m_sample = 8'h00; end
            else if (cmd[15:14] == 2'b10) begin
                w = {8'hFF, cmd[7:0]};
                if (a < 6'd22) m_regs[a] = cmd[7:0];
            end
            else if (cmd[15:14] == 2'b11) w = {8'h00, m_read(a)};
            r = {w, w, w, w};
        end
    endtask

    // One frame: nedges sclk pulses, samples A before each rise and B before each fall
    task automatic send_frame(input logic [15:0] cmd, input int nedges, input int gap,
                              output logic [63:0] got, output logic [63:0] exp);
        logic [15:0] a0, b0, a1, b1;
        logic [63:0] r;
        a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
        spi.csn  = 1'b0;
        spi.sclk = 1'b0;
        spi.copi = cmd[15];
        repeat (6) @(negedge clk);
        for (int i = 0; i < nedges; i++) begin
            if (i < 16) begin a0[15-i] = spi.cipo0; a1[15-i] = spi.cipo1; end
            spi.sclk = 1'b1;
            repeat (4) @(negedge clk);
            if (i < 16) begin b0[15-i] = spi.cipo0; b1[15-i] = spi.cipo1; end
            spi.sclk = 1'b0;
            spi.copi = (i < 15) ? cmd[14-i] : 1'b0;
            repeat (4) @(negedge clk);
        end
        spi.csn = 1'b1;
        repeat (gap) @(negedge clk);
        got = {a0, b0, a1, b1};
        if (nedges == 16) begin
            exp = sb_q.pop_front();
            model_exec(cmd, r);
            sb_q.push_back(r);
            m_frames++;
        end else begin
            exp = sb_q[0];
            if (m_errors < 65535) m_errors++;
        end
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        spi.csn  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (spi.cipo0 !== 1'b0) begin n_errors++; $display("FAIL reset_cipo0 got %b expected 0", spi.cipo0); end
        n_checks++; if (spi.cipo1 !== 1'b0) begin n_errors++; $display("FAIL reset_cipo1 got %b expected 0", spi.cipo1); end
        n_checks++; if (frame_count !== 32'd0) begin n_errors++; $display("FAIL reset_frame_count got %0d expected 0", frame_count); end
        n_checks++; if (error_count !== 16'd0) begin n_errors++; $display("FAIL reset_error_count got %0d expected 0", error_count); end
    endtask

    task automatic test_write_convert();
        logic [15:0] cmds [6];
        logic [63:0] got, exp;
        cmds = '{16'h8A5C, 16'h0100, 16'h0100, 16'hCA00, 16'h0100, 16'h0100};
        for (int i = 0; i < 6; i++) begin
            send_frame(cmds[i], 16, 6, got, exp);
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL wr_conv_sb frame %0d got %h expected %h", i, got, exp); end
            if (i == 2) begin
                n_checks++; if (got !== 64'hFF5C_FF5C_FF5C_FF5C) begin n_errors++; $display("FAIL write_echo got %h expected ff5cff5cff5cff5c", got); end
            end
            if (i == 5) begin
                n_checks++; if (got !== 64'h005C_005C_005C_005C) begin n_errors++; $display("FAIL read_reg10 got %h expected 005c005c005c005c", got); end
            end
        end
        n_checks++; if (frame_count !== 32'(m_frames)) begin n_errors++; $display("FAIL wr_conv_frames got %0d expected %0d", frame_count, m_frames); end
    endtask

    task automatic test_read_id();
        logic [15:0] cmds [9];
        logic [15:0] lit  [9];
        logic [63:0] got, exp;
        cmds = '{16'hE800, 16'hE900, 16'hEA00, 16'hEB00, 16'hEC00, 16'hFE00, 16'hFF00, 16'h0100, 16'h0100};
        lit  = '{16'h0, 16'h0, 16'h0049, 16'h004E, 16'h0054, 16'h0041, 16'h004E, 16'h0040, 16'h0004};
        for (int i = 0; i < 9; i++) begin
            send_frame(cmds[i], 16, 6, got, exp);
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL read_id_sb frame %0d got %h expected %h", i, got, exp); end
            if (i >= 2) begin
                n_checks++; if (got !== {lit[i], lit[i], lit[i], lit[i]}) begin n_errors++; $display("FAIL read_id_const frame %0d got %h expected word %h", i, got, lit[i]); end
            end
        end
    endtask

    task automatic test_convert_ddr();
        logic [63:0] got, exp;
        for (int i = 0; i < 7; i++) begin
            send_frame((i == 0) ? 16'h6A00 : 16'h0000, 16, 6, got, exp);
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL convert_sb frame %0d got %h expected %h", i, got, exp); end
            if (i == 3) begin
                n_checks++; if (got !== 64'h0000_4000_8000_C000) begin n_errors++; $display("FAIL convert_lanes got %h expected 0000400080 00c000", got); end
            end
            if (i == 5) begin
                n_checks++; if (got !== 64'h0002_4002_8002_C002) begin n_errors++; $display("FAIL convert_sample2 got %h expected 0002400280 02c002", got); end
            end
        end
    endtask

    task automatic test_short_frame();
        logic [63:0] got, exp;
        logic [31:0] fc_before;
        fc_before = frame_count;
        send_frame(16'h0000, 9, 6, got, exp);
        n_checks++; if (error_count !== 16'd1) begin n_errors++; $display("FAIL short_errors got %0d expected 1", error_count); end
        n_checks++; if (frame_count !== fc_before) begin n_errors++; $display("FAIL short_frames got %0d expected %0d", frame_count, fc_before); end
        send_frame(16'h0100, 16, 6, got, exp);
        n_checks++; if (got !== exp) begin n_errors++; $display("FAIL short_pipe got %h expected %h", got, exp); end
    endtask

    task automatic test_long_frame();
        logic [15:0] cmds [3];
        logic [63:0] got, exp;
        send_frame(16'h85AA, 17, 6, got, exp);
        n_checks++; if (error_count !== 16'(m_errors)) begin n_errors++; $display("FAIL long_errors got %0d expected %0d", error_count, m_errors); end
        n_checks++; if (frame_count !== 32'(m_frames)) begin n_errors++; $display("FAIL long_frames got %0d expected %0d", frame_count, m_frames); end
        cmds = '{16'hC500, 16'h0100, 16'h0100};
        for (int i = 0; i < 3; i++) begin
            send_frame(cmds[i], 16, 6, got, exp);
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL long_sb frame %0d got %h expected %h", i, got, exp); end
        end
        n_checks++; if (got !== 64'h0) begin n_errors++; $display("FAIL long_not_executed got %h expected 0", got); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cmds [4];
        logic [63:0] got, exp;
        cmds = '{16'h8133, 16'hC100, 16'h0100, 16'h0100};
        for (int i = 0; i < 4; i++) begin
            send_frame(cmds[i], 16, (i == 3) ? 6 : 1, got, exp);
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL b2b_sb frame %0d got %h expected %h", i, got, exp); end
        end
        n_checks++; if (got !== 64'h0033_0033_0033_0033) begin n_errors++; $display("FAIL b2b_read got %h expected 0033003300330033", got); end
        n_checks++; if (frame_count !== 32'(m_frames)) begin n_errors++; $display("FAIL b2b_frames got %0d expected %0d", frame_count, m_frames); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] cmds [3];
        logic [63:0] got, exp;
        send_frame(16'h8011, 16, 6, got, exp);
        send_frame(16'h0100, 16, 6, got, exp);
        spi.csn  = 1'b0;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        repeat (6) @(negedge clk);
        spi.sclk = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (spi.cipo0 !== 1'b1) begin n_errors++; $display("FAIL mid_pre_cipo0 got %b expected 1", spi.cipo0); end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (spi.cipo0 !== 1'b0) begin n_errors++; $display("FAIL mid_rst_cipo0 got %b expected 0", spi.cipo0); end
        n_checks++; if (spi.cipo1 !== 1'b0) begin n_errors++; $display("FAIL mid_rst_cipo1 got %b expected 0", spi.cipo1); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        spi.sclk = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (frame_count !== 32'd0) begin n_errors++; $display("FAIL mid_frames got %0d expected 0", frame_count); end
        n_checks++; if (error_count !== 16'd0) begin n_errors++; $display("FAIL mid_errors got %0d expected 0", error_count); end
        spi.csn = 1'b1;
        repeat (6) @(negedge clk);
        cmds = '{16'hC000, 16'h0100, 16'h0100};
        for (int i = 0; i < 3; i++) begin
            send_frame(cmds[i], 16, 6, got, exp);
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL mid_sb frame %0d got %h expected %h", i, got, exp); end
            if (i == 0) begin
                n_checks++; if (got !== 64'h0) begin n_errors++; $display("FAIL mid_first_zero got %h expected 0", got); end
            end
        end
        n_checks++; if (frame_count !== 32'd3) begin n_errors++; $display("FAIL mid_fresh_frames got %0d expected 3", frame_count); end
    endtask

    initial begin
        rstn     = 1'b0;
        spi.csn  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        test_reset();
        test_write_convert();
        test_read_id();
        test_convert_ddr();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
